// File: rtl/mpi_arb_pkg.sv
// Shared widths, FSM encoding and command record for the two-requester memory arbiter.
package mpi_arb_pkg;

    localparam int ADDR_W             = 15;
    localparam int DATA_W             = 64;
    localparam int RD_TIMEOUT_DEFAULT = 1024;
    localparam int CNT_W              = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    // One captured command: read flag, address and write data.
    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/mpi_arb_slot.sv
// One-entry pending command slot: captures a requester strobe, clears when granted,
// and flags a discarded command when it is already occupied.
module mpi_arb_slot
    import mpi_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              rden,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_wr,
    input  logic              grant,
    output logic              valid,
    output cmd_t              cmd,
    output logic              drop
);

    logic valid_reg;
    logic drop_reg;
    cmd_t cmd_reg;
    logic load;

    // A slot being emptied on this edge can accept the new command in the same edge.
    assign load = cs & (~valid_reg | grant);

    // Capture, clear on grant, and one-cycle drop pulse for a command that found the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            drop_reg  <= 1'b0;
            cmd_reg   <= '0;
        end else begin
            drop_reg <= cs & valid_reg & ~grant;
            if (load) begin
                valid_reg    <= 1'b1;
                cmd_reg.rd   <= rden;
                cmd_reg.addr <= addr;
                cmd_reg.data <= data_wr;
            end else if (grant) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign valid = valid_reg;
    assign cmd   = cmd_reg;
    assign drop  = drop_reg;

endmodule

// File: rtl/mpi_arb.sv
// Two-requester round-robin arbiter onto a single memory port with one transaction
// outstanding and a read-return timeout.
module mpi_arb
    import mpi_arb_pkg::*;
#(
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              m0_cs,
    input  logic              m0_wren,
    input  logic              m0_rden,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_wr,
    output logic              m0_rd_rdy,
    output logic [DATA_W-1:0] m0_data_rd,
    output logic              m0_busy,
    output logic              m0_drop,
    // requester 1
    input  logic              m1_cs,
    input  logic              m1_wren,
    input  logic              m1_rden,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_wr,
    output logic              m1_rd_rdy,
    output logic [DATA_W-1:0] m1_data_rd,
    output logic              m1_busy,
    output logic              m1_drop,
    // shared memory port
    output logic              s_cs,
    output logic              s_wren,
    output logic              s_rden,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data_wr,
    input  logic              s_rd_rdy,
    input  logic [DATA_W-1:0] s_data_rd,
    output logic              rd_timeout
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

    // The command type is decided by rden alone, so wren carries no information.
    logic unused_wren;
    assign unused_wren = m0_wren ^ m1_wren;

    logic [1:0]        cs_vec;
    logic [1:0]        rden_vec;
    logic [ADDR_W-1:0] addr_vec [2];
    logic [DATA_W-1:0] data_vec [2];
    logic [1:0]        slot_valid;
    logic [1:0]        slot_drop;
    logic [1:0]        grant_vec;
    cmd_t              slot_cmd [2];

    assign cs_vec      = {m1_cs, m0_cs};
    assign rden_vec    = {m1_rden, m0_rden};
    assign addr_vec[0] = m0_addr;
    assign addr_vec[1] = m1_addr;
    assign data_vec[0] = m0_data_wr;
    assign data_vec[1] = m1_data_wr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            mpi_arb_slot u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .cs      (cs_vec[gi]),
                .rden    (rden_vec[gi]),
                .addr    (addr_vec[gi]),
                .data_wr (data_vec[gi]),
                .grant   (grant_vec[gi]),
                .valid   (slot_valid[gi]),
                .cmd     (slot_cmd[gi]),
                .drop    (slot_drop[gi])
            );
        end
    endgenerate

    assign m0_busy = slot_valid[0];
    assign m1_busy = slot_valid[1];
    assign m0_drop = slot_drop[0];
    assign m1_drop = slot_drop[1];

    state_t            state_reg;
    logic              last_grant_reg;
    logic              owner_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              s_cs_reg;
    logic              s_rden_reg;
    logic              s_wren_reg;
    logic [ADDR_W-1:0] s_addr_reg;
    logic [DATA_W-1:0] s_data_wr_reg;
    logic [1:0]        rd_rdy_reg;
    logic [DATA_W-1:0] data_rd_reg [2];
    logic              rd_timeout_reg;

    logic pick;
    cmd_t sel_cmd;

    // Winner selection: alternate when both are pending, otherwise take whichever is pending.
    always_comb begin
        pick = 1'b0;
        if (&slot_valid) begin
            pick = ~last_grant_reg;
        end else begin
            pick = ~slot_valid[0];
        end
        grant_vec = 2'b00;
        if (state_reg == ST_IDLE && |slot_valid) begin
            grant_vec = pick ? 2'b10 : 2'b01;
        end
        sel_cmd = slot_cmd[pick];
    end

    // Transaction sequencer: issue one command, then wait for its read data or give up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            s_cs_reg       <= 1'b0;
            s_rden_reg     <= 1'b0;
            s_wren_reg     <= 1'b0;
            s_addr_reg     <= '0;
            s_data_wr_reg  <= '0;
            rd_rdy_reg     <= 2'b00;
            data_rd_reg[0] <= '0;
            data_rd_reg[1] <= '0;
            rd_timeout_reg <= 1'b0;
        end else begin
            rd_rdy_reg     <= 2'b00;
            rd_timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|slot_valid) begin
                        s_cs_reg       <= 1'b1;
                        s_rden_reg     <= sel_cmd.rd;
                        s_wren_reg     <= ~sel_cmd.rd;
                        s_addr_reg     <= sel_cmd.addr;
                        s_data_wr_reg  <= sel_cmd.data;
                        owner_reg      <= pick;
                        last_grant_reg <= pick;
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    s_cs_reg <= 1'b0;
                    if (s_rden_reg) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_RD;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_WAIT_RD: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (s_rd_rdy) begin
                        data_rd_reg[owner_reg] <= s_data_rd;
                        rd_rdy_reg[owner_reg]  <= 1'b1;
                        state_reg              <= ST_IDLE;
                    end else if (cnt_reg == TO_LAST) begin
                        rd_timeout_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    s_cs_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_cs       = s_cs_reg;
    assign s_rden     = s_rden_reg;
    assign s_wren     = s_wren_reg;
    assign s_addr     = s_addr_reg;
    assign s_data_wr  = s_data_wr_reg;
    assign m0_rd_rdy  = rd_rdy_reg[0];
    assign m1_rd_rdy  = rd_rdy_reg[1];
    assign m0_data_rd = data_rd_reg[0];
    assign m1_data_rd = data_rd_reg[1];
    assign rd_timeout = rd_timeout_reg;

endmodule

// File: tb/tb_mpi_arb.sv
// Directed bench for mpi_arb: arbitration order, issue latency, slot hold/drop,
// read timeout and its boundary, and reset in the middle of a read.
module tb_mpi_arb;
    import mpi_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_cs, m0_wren, m0_rden;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_data_wr;
    logic              m0_rd_rdy, m0_busy, m0_drop;
    logic [DATA_W-1:0] m0_data_rd;
    logic              m1_cs, m1_wren, m1_rden;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_data_wr;
    logic              m1_rd_rdy, m1_busy, m1_drop;
    logic [DATA_W-1:0] m1_data_rd;
    logic              s_cs, s_wren, s_rden;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data_wr;
    logic              s_rd_rdy;
    logic [DATA_W-1:0] s_data_rd;
    logic              rd_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mpi_arb #(.RD_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_cs      (m0_cs),
        .m0_wren    (m0_wren),
        .m0_rden    (m0_rden),
        .m0_addr    (m0_addr),
        .m0_data_wr (m0_data_wr),
        .m0_rd_rdy  (m0_rd_rdy),
        .m0_data_rd (m0_data_rd),
        .m0_busy    (m0_busy),
        .m0_drop    (m0_drop),
        .m1_cs      (m1_cs),
        .m1_wren    (m1_wren),
        .m1_rden    (m1_rden),
        .m1_addr    (m1_addr),
        .m1_data_wr (m1_data_wr),
        .m1_rd_rdy  (m1_rd_rdy),
        .m1_data_rd (m1_data_rd),
        .m1_busy    (m1_busy),
        .m1_drop    (m1_drop),
        .s_cs       (s_cs),
        .s_wren     (s_wren),
        .s_rden     (s_rden),
        .s_addr     (s_addr),
        .s_data_wr  (s_data_wr),
        .s_rd_rdy   (s_rd_rdy),
        .s_data_rd  (s_data_rd),
        .rd_timeout (rd_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_cmd(input logic rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        m0_cs = 1'b1; m0_rden = rd; m0_wren = ~rd; m0_addr = a; m0_data_wr = d;
    endtask

    task automatic m1_cmd(input logic rd, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        m1_cs = 1'b1; m1_rden = rd; m1_wren = ~rd; m1_addr = a; m1_data_wr = d;
    endtask

    task automatic idle_cmds();
        m0_cs = 1'b0; m1_cs = 1'b0;
    endtask

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        m0_cs = 0; m0_wren = 0; m0_rden = 0; m0_addr = '0; m0_data_wr = '0;
        m1_cs = 0; m1_wren = 0; m1_rden = 0; m1_addr = '0; m1_data_wr = '0;
        s_rd_rdy = 0; s_data_rd = '0;

        // Reset state
        #3;
        chk("rst_s_cs", 64'(s_cs), 64'd0);
        chk("rst_s_wren", 64'(s_wren), 64'd0);
        chk("rst_m0_busy", 64'(m0_busy), 64'd0);
        chk("rst_m1_busy", 64'(m1_busy), 64'd0);
        chk("rst_timeout", 64'(rd_timeout), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Simultaneous reads: m0 wins first after reset, then m1
        m0_cmd(1'b1, 15'h0100, 64'h0);
        m1_cmd(1'b1, 15'h0200, 64'h0);
        step(); idle_cmds();
        chk("rr_busy0", 64'(m0_busy), 64'd1);
        chk("rr_busy1", 64'(m1_busy), 64'd1);
        chk("rr_scs_gap", 64'(s_cs), 64'd0);
        step();
        chk("rr_scs0", 64'(s_cs), 64'd1);
        chk("rr_addr0", 64'(s_addr), 64'h0100);
        chk("rr_rden0", 64'(s_rden), 64'd1);
        chk("rr_wren0", 64'(s_wren), 64'd0);
        chk("rr_busy0_clr", 64'(m0_busy), 64'd0);
        chk("rr_busy1_hold", 64'(m1_busy), 64'd1);
        step();
        chk("rr_scs0_off", 64'(s_cs), 64'd0);
        step(); step();
        s_rd_rdy = 1'b1; s_data_rd = 64'hA;
        step(); s_rd_rdy = 1'b0;
        chk("rr_m0_rdy", 64'(m0_rd_rdy), 64'd1);
        chk("rr_m0_data", m0_data_rd, 64'hA);
        chk("rr_m1_rdy_quiet", 64'(m1_rd_rdy), 64'd0);
        step();
        chk("rr_m0_rdy_pulse", 64'(m0_rd_rdy), 64'd0);
        chk("rr_scs1", 64'(s_cs), 64'd1);
        chk("rr_addr1", 64'(s_addr), 64'h0200);
        chk("rr_busy1_clr", 64'(m1_busy), 64'd0);
        step(); step(); step();
        s_rd_rdy = 1'b1; s_data_rd = 64'hA;
        step(); s_rd_rdy = 1'b0;
        chk("rr_m1_rdy", 64'(m1_rd_rdy), 64'd1);
        chk("rr_m1_data", m1_data_rd, 64'hA);
        chk("rr_m0_rdy_quiet", 64'(m0_rd_rdy), 64'd0);
        step();
        chk("rr_m1_rdy_pulse", 64'(m1_rd_rdy), 64'd0);

        // Single write from m0, two-cycle latency, outputs hold afterwards
        m0_cmd(1'b0, 15'h0010, 64'h1122334455667788);
        step(); idle_cmds();
        chk("wr_busy0", 64'(m0_busy), 64'd1);
        chk("wr_scs_gap", 64'(s_cs), 64'd0);
        step();
        chk("wr_scs", 64'(s_cs), 64'd1);
        chk("wr_addr", 64'(s_addr), 64'h0010);
        chk("wr_data", s_data_wr, 64'h1122334455667788);
        chk("wr_wren", 64'(s_wren), 64'd1);
        chk("wr_rden", 64'(s_rden), 64'd0);
        chk("wr_busy0_clr", 64'(m0_busy), 64'd0);
        step();
        chk("wr_scs_off", 64'(s_cs), 64'd0);
        chk("wr_addr_hold", 64'(s_addr), 64'h0010);
        chk("wr_data_hold", s_data_wr, 64'h1122334455667788);

        // m1 three back-to-back commands: first issued, second held, third dropped
        m1_cmd(1'b1, 15'h0401, 64'h0);
        step();
        chk("bb_busy1_a", 64'(m1_busy), 64'd1);
        chk("bb_drop1_a", 64'(m1_drop), 64'd0);
        m1_cmd(1'b0, 15'h0402, 64'h22);
        step();
        chk("bb_scs", 64'(s_cs), 64'd1);
        chk("bb_addr_rd", 64'(s_addr), 64'h0401);
        chk("bb_busy1_b", 64'(m1_busy), 64'd1);
        chk("bb_drop1_b", 64'(m1_drop), 64'd0);
        m1_cmd(1'b0, 15'h0403, 64'h33);
        step(); idle_cmds();
        chk("bb_drop1_c", 64'(m1_drop), 64'd1);
        chk("bb_busy1_c", 64'(m1_busy), 64'd1);
        step();
        chk("bb_drop1_pulse", 64'(m1_drop), 64'd0);
        s_rd_rdy = 1'b1; s_data_rd = 64'h55;
        step(); s_rd_rdy = 1'b0;
        chk("bb_m1_rdy", 64'(m1_rd_rdy), 64'd1);
        chk("bb_m1_data", m1_data_rd, 64'h55);
        step();
        chk("bb_scs2", 64'(s_cs), 64'd1);
        chk("bb_addr2", 64'(s_addr), 64'h0402);
        chk("bb_data2", s_data_wr, 64'h22);
        chk("bb_wren2", 64'(s_wren), 64'd1);
        chk("bb_busy1_d", 64'(m1_busy), 64'd0);
        step(); step();
        chk("bb_no_third", 64'(s_cs), 64'd0);
        chk("bb_addr_final", 64'(s_addr), 64'h0402);

        // Read timeout after 8 wait cycles; late return ignored
        m0_cmd(1'b1, 15'h0500, 64'h0);
        step(); idle_cmds();
        step(); step();
        repeat (7) step();
        chk("to_not_yet", 64'(rd_timeout), 64'd0);
        step();
        chk("to_pulse", 64'(rd_timeout), 64'd1);
        chk("to_no_rdy", 64'(m0_rd_rdy), 64'd0);
        s_rd_rdy = 1'b1; s_data_rd = 64'hDEAD;
        step();
        chk("to_pulse_end", 64'(rd_timeout), 64'd0);
        chk("to_late_rdy0", 64'(m0_rd_rdy), 64'd0);
        chk("to_data_hold", m0_data_rd, 64'hA);
        step(); s_rd_rdy = 1'b0;
        chk("to_late_rdy0_b", 64'(m0_rd_rdy), 64'd0);
        chk("to_late_rdy1", 64'(m1_rd_rdy), 64'd0);
        chk("to_idle_scs", 64'(s_cs), 64'd0);

        // Return on the timeout cycle wins over the timeout
        m0_cmd(1'b1, 15'h0501, 64'h0);
        step(); idle_cmds();
        step(); step();
        repeat (7) step();
        s_rd_rdy = 1'b1; s_data_rd = 64'h77;
        step(); s_rd_rdy = 1'b0;
        chk("edge_rdy", 64'(m0_rd_rdy), 64'd1);
        chk("edge_data", m0_data_rd, 64'h77);
        chk("edge_no_to", 64'(rd_timeout), 64'd0);
        step();
        chk("edge_no_to_b", 64'(rd_timeout), 64'd0);

        // Reset during WAIT_RD with m0 slot occupied
        m0_cmd(1'b1, 15'h0600, 64'h0);
        step(); idle_cmds();
        step(); step();
        m0_cmd(1'b0, 15'h0601, 64'h99);
        step(); idle_cmds();
        chk("mr_busy0", 64'(m0_busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy0_clr", 64'(m0_busy), 64'd0);
        chk("mr_addr", 64'(s_addr), 64'd0);
        chk("mr_wdata", s_data_wr, 64'd0);
        chk("mr_rden", 64'(s_rden), 64'd0);
        chk("mr_m0_data", m0_data_rd, 64'd0);
        chk("mr_m1_data", m1_data_rd, 64'd0);
        step();
        rst_n = 1'b1;
        s_rd_rdy = 1'b1; s_data_rd = 64'hBAD;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 2) s_rd_rdy = 1'b0;
            chk("mr_quiet_scs", 64'(s_cs), 64'd0);
            chk("mr_quiet_act", 64'({m0_rd_rdy, m1_rd_rdy, m0_drop, m1_drop, rd_timeout, m0_busy}), 64'd0);
        end
        chk("mr_m0_data_after", m0_data_rd, 64'd0);
        m1_cmd(1'b0, 15'h0700, 64'h1);
        step(); idle_cmds();
        step();
        chk("mr_alive_scs", 64'(s_cs), 64'd1);
        chk("mr_alive_addr", 64'(s_addr), 64'h0700);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpi_arb.md
MPI_ARB -- requirements
Module: mpi_arb

Interface
REQ-001 Parameter RD_TIMEOUT, default 1024, meaning read-wait cycles before abort (valid range 1..2^16-1).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m0_cs, m0_wren, m0_rden  input  1 each  requester 0 command strobe and type; m0_cs is a one-cycle pulse.
REQ-005 m0_addr  input  15, m0_data_wr  input  64  requester 0 address and write data, valid while m0_cs=1.
REQ-006 m0_rd_rdy  output  1, m0_data_rd  output  64  requester 0 read-return pulse and data.
REQ-007 m0_busy  output  1  requester 0 pending slot full; m0_drop  output  1  one-cycle pulse, command discarded.
REQ-008 m1_* ports identical to REQ-004..REQ-007 for requester 1.
REQ-009 s_cs, s_wren, s_rden  output  1 each; s_addr  output  15; s_data_wr  output  64  shared memory port command.
REQ-010 s_rd_rdy  input  1, s_data_rd  input  64  shared memory read return.
REQ-011 rd_timeout  output  1  one-cycle pulse on read abort.

Function
REQ-012 Each requester SHALL own a one-entry pending slot; command is read iff rden=1, else write; wren is ignored.
REQ-013 mX_cs with slot empty, or with slot being granted on the same edge, SHALL load the slot; mX_busy = slot valid.
REQ-014 mX_cs with slot full and not granted that edge SHALL discard the command and pulse mX_drop for one cycle.
REQ-015 FSM states IDLE, ISSUE, WAIT_RD; reset state IDLE.
REQ-016 IDLE: if any slot valid, grant, clear that slot, register s_* from it, s_cs=1 for exactly one cycle, go ISSUE.
REQ-017 Arbitration SHALL be round-robin: when both slots valid, grant the requester not granted last; last-grant resets to 1 (requester 0 wins first).
REQ-018 ISSUE: s_cs deasserts; write -> IDLE; read -> WAIT_RD and clear timeout counter.
REQ-019 Latency: s_cs SHALL be high the second cycle after the edge that sampled mX_cs with idle FSM and empty slots (one-cycle issue gap between back-to-back commands).
REQ-020 WAIT_RD: on s_rd_rdy=1, register s_data_rd to owner's mX_data_rd, pulse owner's mX_rd_rdy one cycle, go IDLE.
REQ-021 WAIT_RD: counter increments per cycle; at RD_TIMEOUT with no s_rd_rdy, pulse rd_timeout, no mX_rd_rdy, go IDLE.
REQ-022 s_rd_rdy outside WAIT_RD SHALL be ignored; s_rd_rdy on the timeout cycle SHALL win (normal return, no rd_timeout).
REQ-023 s_addr, s_data_wr, s_wren, s_rden SHALL hold their last values when s_cs=0; s_wren = ~s_rden.
REQ-024 mX_data_rd SHALL hold its last value between returns; non-owner rd_rdy stays 0.
REQ-025 Slot capture SHALL continue during ISSUE/WAIT_RD; at most one memory transaction outstanding.

Reset
REQ-026 rst_n low SHALL asynchronously clear: FSM to IDLE, slots empty, last-grant=1, counter 0, all outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it silently; no rd_rdy, drop or timeout pulse after release.

Structure
REQ-028 Shared package holds ADDR_W=15, DATA_W=64, FSM state encodings, RD_TIMEOUT default.
REQ-029 One sub-module, mpi_arb_slot (pending slot capture/clear/drop), instantiated twice.

Verification
REQ-030 m0 write addr 0x0010 data 0x1122334455667788 -> s_cs high 2 cycles later with same addr/data, s_wren=1; m0_busy low after grant.
REQ-031 m0 and m1 reads same cycle, memory returns 0xA after 3 cycles each -> m0 issued first, m0_rd_rdy data 0xA, then m1 issued, m1_rd_rdy only.
REQ-032 m1 issues 3 commands on consecutive cycles while FSM in WAIT_RD -> 2nd held, 3rd dropped with m1_drop pulse.
REQ-033 RD_TIMEOUT=8, read with no s_rd_rdy -> rd_timeout pulse after 8 WAIT_RD cycles, FSM IDLE, later s_rd_rdy ignored.
REQ-034 rst_n low during WAIT_RD with m0 slot full -> all outputs 0 immediately; no activity after release until new mX_cs.
